// File: rtl/sha256_pkg.sv
// Shared SHA256 sequencing types: block types, length words, widths, FSM states.
package sha256_pkg;

    localparam int BLK_W = 512;
    localparam int DIG_W = 256;
    localparam int JOB_W = 640;

    typedef enum logic [1:0] {
        BT_HASH        = 2'd0,
        BT_MERKLE_LEAF = 2'd1,
        BT_HEADER      = 2'd2,
        BT_ILLEGAL     = 2'd3
    } blk_type_e;

    // Message length words (bits) that close the final padded block.
    localparam logic [63:0] LEN_HASH   = 64'h100;
    localparam logic [63:0] LEN_MERKLE = 64'h200;
    localparam logic [63:0] LEN_HEADER = 64'h280;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_CORE = 2'd1,
        S_RUN      = 2'd2,
        S_RESULT   = 2'd3
    } seq_state_e;

    // A 256-bit message always fits one block: data, stop bit, zeros, length.
    function automatic logic [BLK_W-1:0] pad_hash256(input logic [DIG_W-1:0] d);
        return {d, 1'b1, 191'b0, LEN_HASH};
    endfunction

endpackage

// File: rtl/sha256_pad_builder.sv
// Combinational padding unit: job type + raw data -> padded blocks, plus the
// single-block padding of a digest for the second hash pass.
module sha256_pad_builder
    import sha256_pkg::*;
(
    input  logic [1:0]       i_type,
    input  logic [JOB_W-1:0] i_data,
    input  logic [DIG_W-1:0] i_digest,
    output logic [BLK_W-1:0] o_block0,
    output logic [BLK_W-1:0] o_block1,
    output logic             o_two_blocks,
    output logic [BLK_W-1:0] o_digest_blk
);

    // Pick the block layout for the job type; illegal type yields zeros.
    always_comb begin
        o_block0     = '0;
        o_block1     = '0;
        o_two_blocks = 1'b0;
        case (blk_type_e'(i_type))
            BT_HASH: begin
                o_block0 = pad_hash256(i_data[639:384]);
            end
            BT_MERKLE_LEAF: begin
                o_block0     = i_data[639:128];
                o_block1     = {1'b1, 447'b0, LEN_MERKLE};
                o_two_blocks = 1'b1;
            end
            BT_HEADER: begin
                o_block0     = i_data[639:128];
                o_block1     = {i_data[127:0], 1'b1, 319'b0, LEN_HEADER};
                o_two_blocks = 1'b1;
            end
            default: begin
                o_two_blocks = 1'b0;
            end
        endcase
    end

    assign o_digest_blk = pad_hash256(i_digest);

endmodule

// File: rtl/sha256d_job_sequencer.sv
// Runs one hashing job at a time through a single SHA256 core, optionally
// re-hashing the first digest, and returns the result over valid/ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | job_ready high, waiting for a job
// RST_CORE | core held in reset RESET_HOLD cycles, block0 on core_msg
// RUN      | core released, waiting for blk_done per block (timed out)
// RESULT   | res_valid high until res_ready
module sha256d_job_sequencer
    import sha256_pkg::*;
#(
    parameter int DOUBLE_HASH    = 1,
    parameter int RESET_HOLD     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_job_valid,
    output logic             o_job_ready,
    input  logic [1:0]       i_job_type,
    input  logic [JOB_W-1:0] i_job_data,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [DIG_W-1:0] o_res_hash,
    output logic             o_res_err,
    output logic [BLK_W-1:0] o_core_msg,
    output logic [1:0]       o_core_blk_type,
    output logic             o_core_nreset,
    input  logic [DIG_W-1:0] i_core_hash,
    input  logic             i_core_blk_done
);

    localparam int HOLD_W = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // A hold of zero is treated as one cycle so the core always sees a reset.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (RESET_HOLD < 1) ? '0 : HOLD_W'(RESET_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        r_state;
    logic              r_job_ready;
    logic              r_res_valid;
    logic [DIG_W-1:0]  r_res_hash;
    logic              r_res_err;
    logic [BLK_W-1:0]  r_core_msg;
    logic [1:0]        r_core_blk_type;
    logic              r_core_nreset;
    logic [BLK_W-1:0]  r_blk1;
    logic              r_last_blk;
    logic              r_blk_idx;
    logic              r_pass;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic [BLK_W-1:0]  w_block0;
    logic [BLK_W-1:0]  w_block1;
    logic              w_two_blocks;
    logic [BLK_W-1:0]  w_digest_blk;

    sha256_pad_builder u_pad (
        .i_type       (i_job_type),
        .i_data       (i_job_data),
        .i_digest     (i_core_hash),
        .o_block0     (w_block0),
        .o_block1     (w_block1),
        .o_two_blocks (w_two_blocks),
        .o_digest_blk (w_digest_blk)
    );

    // Job sequencing FSM with registered handshake and core-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_job_ready     <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_hash      <= '0;
            r_res_err       <= 1'b0;
            r_core_msg      <= '0;
            r_core_blk_type <= '0;
            r_core_nreset   <= 1'b0;
            r_blk1          <= '0;
            r_last_blk      <= 1'b0;
            r_blk_idx       <= 1'b0;
            r_pass          <= 1'b0;
            r_hold_cnt      <= '0;
            r_to_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_job_ready <= 1'b1;
                    if (i_job_valid && r_job_ready) begin
                        r_job_ready <= 1'b0;
                        if (i_job_type == BT_ILLEGAL) begin
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_hash  <= '0;
                            r_state     <= S_RESULT;
                        end else begin
                            r_core_msg      <= w_block0;
                            r_blk1          <= w_block1;
                            r_last_blk      <= w_two_blocks;
                            r_blk_idx       <= 1'b0;
                            r_pass          <= 1'b0;
                            r_core_blk_type <= i_job_type;
                            r_core_nreset   <= 1'b0;
                            r_hold_cnt      <= HOLD_LOAD;
                            r_state         <= S_RST_CORE;
                        end
                    end
                end
                S_RST_CORE: begin
                    if (r_hold_cnt == '0) begin
                        r_core_nreset <= 1'b1;
                        r_to_cnt      <= TO_LOAD;
                        r_state       <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_core_blk_done) begin
                        r_to_cnt <= TO_LOAD;
                        if (r_blk_idx != r_last_blk) begin
                            r_blk_idx  <= 1'b1;
                            r_core_msg <= r_blk1;
                        end else if ((DOUBLE_HASH != 0) && !r_pass) begin
                            r_core_msg      <= w_digest_blk;
                            r_core_blk_type <= BT_HASH;
                            r_last_blk      <= 1'b0;
                            r_blk_idx       <= 1'b0;
                            r_pass          <= 1'b1;
                            r_core_nreset   <= 1'b0;
                            r_hold_cnt      <= HOLD_LOAD;
                            r_state         <= S_RST_CORE;
                        end else begin
                            r_res_hash    <= i_core_hash;
                            r_res_err     <= 1'b0;
                            r_res_valid   <= 1'b1;
                            r_core_nreset <= 1'b0;
                            r_state       <= S_RESULT;
                        end
                    end else if (r_to_cnt == '0) begin
                        r_res_hash    <= '0;
                        r_res_err     <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_core_nreset <= 1'b0;
                        r_state       <= S_RESULT;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                    end
                end
                S_RESULT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_job_ready     = r_job_ready;
    assign o_res_valid     = r_res_valid;
    assign o_res_hash      = r_res_hash;
    assign o_res_err       = r_res_err;
    assign o_core_msg      = r_core_msg;
    assign o_core_blk_type = r_core_blk_type;
    assign o_core_nreset   = r_core_nreset;

endmodule

// File: tb/tb_sha256d_job_sequencer.sv
// Bench for sha256d_job_sequencer: two instances (double and single hash)
// driven against a behavioural SHA256 core stub with a real compression model.
module tb_sha256d_job_sequencer;

    localparam int LAT = 5;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [639:0] GENESIS = {
        32'h01000000, 256'h0,
        256'h3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GENESIS_DH = 256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
    localparam logic [255:0] LEAF = 256'hcdd1babe_01234567_89abcdef_01234567_89abcdef_01234567_89abcdef_328e1361;
    localparam logic [639:0] MERKLE = {LEAF, LEAF, 128'h0};
    localparam logic [639:0] XDATA = {256'hdeadbeef_00112233_44556677_8899aabb_ccddeeff_0f1e2d3c_4b5a6978_87960514, 384'hffff_0000_a5a5};
    localparam logic [639:0] YDATA = {256'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777, 384'h1};

    logic        clk;
    logic        rst   [2];
    logic        jv    [2];
    logic        jr    [2];
    logic [1:0]  jt    [2];
    logic [639:0] jd   [2];
    logic        rv    [2];
    logic        rr    [2];
    logic [255:0] rh   [2];
    logic        re    [2];
    logic [511:0] cmsg [2];
    logic [1:0]  cbt   [2];
    logic        cnr   [2];
    logic [255:0] chash[2];
    logic        done  [2];
    logic        hang  [2];
    logic [255:0] cst  [2];
    int          ccnt  [2];

    int n_cmp = 0;
    int n_bad = 0;

    sha256d_job_sequencer #(.DOUBLE_HASH(1), .RESET_HOLD(2), .TIMEOUT_CYCLES(16)) u_dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_job_valid(jv[0]), .o_job_ready(jr[0]),
        .i_job_type(jt[0]), .i_job_data(jd[0]), .o_res_valid(rv[0]), .i_res_ready(rr[0]),
        .o_res_hash(rh[0]), .o_res_err(re[0]), .o_core_msg(cmsg[0]), .o_core_blk_type(cbt[0]),
        .o_core_nreset(cnr[0]), .i_core_hash(chash[0]), .i_core_blk_done(done[0]));

    sha256d_job_sequencer #(.DOUBLE_HASH(0), .RESET_HOLD(3), .TIMEOUT_CYCLES(16)) u_dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_job_valid(jv[1]), .o_job_ready(jr[1]),
        .i_job_type(jt[1]), .i_job_data(jd[1]), .o_res_valid(rv[1]), .i_res_ready(rr[1]),
        .o_res_hash(rh[1]), .o_res_err(re[1]), .o_core_msg(cmsg[1]), .o_core_blk_type(cbt[1]),
        .o_core_nreset(cnr[1]), .i_core_hash(chash[1]), .i_core_blk_done(done[1]));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
    endfunction

    // Standard SHA256 padding of the top L bits of data into up to two blocks.
    function automatic logic [1023:0] pad_msg(input logic [639:0] data, input int L);
        logic [1023:0] b;
        b = {data, 384'b0};
        b = b & ~({1024{1'b1}} >> L);
        b[1023 - L] = 1'b1;
        if (L + 65 <= 512) b[575:512] = 64'(L);
        else b[63:0] = 64'(L);
        return b;
    endfunction

    function automatic logic [255:0] sha_msg(input logic [639:0] data, input int L);
        logic [1023:0] b;
        logic [255:0] st;
        b  = pad_msg(data, L);
        st = sha_compress(IV, b[1023:512]);
        if (L + 65 > 512) st = sha_compress(st, b[511:0]);
        return st;
    endfunction

    function automatic logic [255:0] sha_dbl(input logic [255:0] h1);
        return sha_msg({h1, 384'b0}, 256);
    endfunction

    // Core stub: restarts from IV while held in reset, one block per LAT cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k] || !cnr[k]) begin
                cst[k]  <= IV;
                ccnt[k] <= 0;
                done[k] <= 1'b0;
            end else if (hang[k]) begin
                done[k] <= 1'b0;
            end else if (ccnt[k] == LAT - 1) begin
                cst[k]   <= sha_compress(cst[k], cmsg[k]);
                chash[k] <= sha_compress(cst[k], cmsg[k]);
                done[k]  <= 1'b1;
                ccnt[k]  <= 0;
            end else begin
                ccnt[k] <= ccnt[k] + 1;
                done[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a job and return at the negedge just after the accepting edge.
    task automatic offer(input int k, input logic [1:0] typ, input logic [639:0] data, output logic ok);
        int w;
        @(negedge clk);
        jv[k] = 1'b1; jt[k] = typ; jd[k] = data;
        w = 0;
        while (!jr[k] && w < 20) begin @(negedge clk); w++; end
        ok = jr[k];
        @(negedge clk);
        jv[k] = 1'b0;
    endtask

    // Run a job until res_valid, recording core activity along the way.
    task automatic start_job(input int k, input logic [1:0] typ, input logic [639:0] data,
                             output int pulses, output int rel, output int win0, output int win1,
                             output int hi, output int cyc, output logic [511:0] msg1, output logic got);
        logic ok;
        logic cap_next;
        int streak;
        pulses = 0; rel = 0; win0 = 0; win1 = 0; hi = 0; cyc = 0; msg1 = '0; got = 1'b0;
        cap_next = 1'b0; streak = 0;
        offer(k, typ, data, ok);
        chk("job_accept", 512'(ok), 512'(1));
        while (cyc < 400) begin
            cyc++;
            if (cap_next) begin msg1 = cmsg[k]; cap_next = 1'b0; end
            if (done[k]) begin pulses++; if (pulses == 1) cap_next = 1'b1; end
            if (!cnr[k]) streak++;
            else begin
                hi++;
                if (streak > 0) begin
                    if (rel == 0) win0 = streak; else if (rel == 1) win1 = streak;
                    rel++;
                    streak = 0;
                end
            end
            if (rv[k]) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("res_valid_seen", 512'(got), 512'(1));
    endtask

    task automatic finish_result(input int k);
        rr[k] = 1'b1;
        @(negedge clk);
        rr[k] = 1'b0;
        chk("res_valid_drop", 512'(rv[k]), 512'(0));
        chk("job_ready_back", 512'(jr[k]), 512'(1));
    endtask

    typedef struct {
        int           k;
        logic [1:0]   typ;
        logic [639:0] data;
        logic         exp_err;
        logic [255:0] exp_hash;
        int           exp_pulses;
        int           exp_rel;
        logic         chk_msg;
        logic [511:0] exp_msg1;
    } vec_t;

    function automatic vec_t mk(input int k, input logic [1:0] typ, input logic [639:0] data,
                                input logic err, input logic [255:0] h, input int p, input int r,
                                input logic cm, input logic [511:0] m1);
        vec_t v;
        v.k = k; v.typ = typ; v.data = data; v.exp_err = err; v.exp_hash = h;
        v.exp_pulses = p; v.exp_rel = r; v.chk_msg = cm; v.exp_msg1 = m1;
        return v;
    endfunction

    initial begin
        vec_t vt [8];
        logic [1023:0] mpad;
        int pulses, rel, win0, win1, hi, cyc, hold, w;
        logic [511:0] msg1;
        logic got, ok, prev;
        logic [255:0] held;

        mpad  = pad_msg(MERKLE, 512);
        vt[0] = mk(0, 2'd2, GENESIS, 1'b0, GENESIS_DH, 3, 2, 1'b0, '0);
        vt[1] = mk(1, 2'd1, MERKLE, 1'b0, sha_msg(MERKLE, 512), 2, 1, 1'b1, mpad[511:0]);
        vt[2] = mk(0, 2'd3, GENESIS, 1'b1, '0, 0, 0, 1'b0, '0);
        vt[3] = mk(1, 2'd0, XDATA, 1'b0, sha_msg(XDATA, 256), 1, 1, 1'b0, '0);
        vt[4] = mk(0, 2'd0, XDATA, 1'b0, sha_dbl(sha_msg(XDATA, 256)), 2, 2, 1'b0, '0);
        vt[5] = mk(1, 2'd2, GENESIS, 1'b0, sha_msg(GENESIS, 640), 2, 1, 1'b0, '0);
        vt[6] = mk(0, 2'd1, MERKLE, 1'b0, sha_dbl(sha_msg(MERKLE, 512)), 3, 2, 1'b1, mpad[511:0]);
        vt[7] = mk(1, 2'd3, XDATA, 1'b1, '0, 0, 0, 1'b0, '0);

        clk = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; jv[k] = 1'b0; jt[k] = '0; jd[k] = '0; rr[k] = 1'b0; hang[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_job_ready", k), 512'(jr[k]), 512'(0));
            chk($sformatf("rst%0d_res_valid", k), 512'(rv[k]), 512'(0));
            chk($sformatf("rst%0d_res_err", k), 512'(re[k]), 512'(0));
            chk($sformatf("rst%0d_res_hash", k), 512'(rh[k]), 512'(0));
            chk($sformatf("rst%0d_core_msg", k), cmsg[k], 512'(0));
            chk($sformatf("rst%0d_core_nreset", k), 512'(cnr[k]), 512'(0));
            rst[k] = 1'b0;
        end
        @(negedge clk);
        chk("job_ready_after_reset", 512'(jr[0]), 512'(1));

        for (int i = 0; i < 8; i++) begin
            hold = (vt[i].k == 0) ? 2 : 3;
            start_job(vt[i].k, vt[i].typ, vt[i].data, pulses, rel, win0, win1, hi, cyc, msg1, got);
            chk($sformatf("v%0d_err", i), 512'(re[vt[i].k]), 512'(vt[i].exp_err));
            chk($sformatf("v%0d_hash", i), 512'(rh[vt[i].k]), 512'(vt[i].exp_hash));
            chk($sformatf("v%0d_pulses", i), 512'(pulses), 512'(vt[i].exp_pulses));
            chk($sformatf("v%0d_releases", i), 512'(rel), 512'(vt[i].exp_rel));
            if (vt[i].exp_rel > 0) chk($sformatf("v%0d_hold0", i), 512'(win0), 512'(hold));
            if (vt[i].exp_rel > 1) chk($sformatf("v%0d_hold1", i), 512'(win1), 512'(hold));
            if (vt[i].typ == 2'd3) chk($sformatf("v%0d_illegal_latency", i), 512'(cyc <= 2), 512'(1));
            if (vt[i].chk_msg) chk($sformatf("v%0d_block1", i), msg1, vt[i].exp_msg1);
            chk($sformatf("v%0d_busy", i), 512'(jr[vt[i].k]), 512'(0));
            finish_result(vt[i].k);
        end

        // Timeout: core never completes a block.
        hang[0] = 1'b1;
        start_job(0, 2'd0, XDATA, pulses, rel, win0, win1, hi, cyc, msg1, got);
        chk("to_run_cycles", 512'(hi), 512'(16));
        chk("to_err", 512'(re[0]), 512'(1));
        chk("to_hash", 512'(rh[0]), 512'(0));
        chk("to_core_nreset", 512'(cnr[0]), 512'(0));
        finish_result(0);
        hang[0] = 1'b0;

        // Backpressure: result held for 50 cycles while another job is offered.
        start_job(1, 2'd0, YDATA, pulses, rel, win0, win1, hi, cyc, msg1, got);
        held = sha_msg(YDATA, 256);
        jv[1] = 1'b1; jt[1] = 2'd0; jd[1] = XDATA;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("bp_res_valid", 512'(rv[1]), 512'(1));
            chk("bp_res_hash", 512'(rh[1]), 512'(held));
            chk("bp_job_ready", 512'(jr[1]), 512'(0));
            chk("bp_core_idle", 512'(cnr[1]), 512'(0));
        end
        jv[1] = 1'b0;
        finish_result(1);
        @(negedge clk);
        chk("bp_no_accept", 512'(jr[1]), 512'(1));

        // Reset while the second pass is running.
        offer(0, 2'd0, XDATA, ok);
        chk("mid_accept", 512'(ok), 512'(1));
        rel = 0; prev = 1'b0; w = 0;
        while (rel < 2 && w < 200) begin
            @(negedge clk);
            if (cnr[0] && !prev) rel++;
            prev = cnr[0];
            w++;
        end
        chk("mid_reach_pass1", 512'(rel), 512'(2));
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("mid_job_ready", 512'(jr[0]), 512'(0));
        chk("mid_res_valid", 512'(rv[0]), 512'(0));
        chk("mid_res_err", 512'(re[0]), 512'(0));
        chk("mid_res_hash", 512'(rh[0]), 512'(0));
        chk("mid_core_msg", cmsg[0], 512'(0));
        chk("mid_core_blk_type", 512'(cbt[0]), 512'(0));
        chk("mid_core_nreset", 512'(cnr[0]), 512'(0));
        rst[0] = 1'b0;
        @(negedge clk);
        chk("mid_job_ready_back", 512'(jr[0]), 512'(1));
        start_job(0, 2'd0, YDATA, pulses, rel, win0, win1, hi, cyc, msg1, got);
        chk("post_rst_err", 512'(re[0]), 512'(0));
        chk("post_rst_hash", 512'(rh[0]), 512'(sha_dbl(sha_msg(YDATA, 256))));
        finish_result(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
